// File: rtl/fifo_pkg.sv
// Shared types, constants and helpers for the gen2 single-clock FIFO.
package fifo_pkg;

  // Read-side behaviour: registered read or first-word-fall-through.
  typedef enum logic {
    STD  = 1'b0,
    FWFT = 1'b1
  } fifo_mode_e;

  // Default build: 8 words, with the flags two words in from either end.
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_AE_THRESH  = 2;
  localparam int DEF_AF_MARGIN  = 2;

  // Each pointer carries one extra wrap bit above the array index.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register array with one write port and one asynchronous
// read port. Contents are deliberately left out of reset.
module fifo_mem #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port: commit one word per enabled edge.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_gen2.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and a selectable FWFT read port.
module fifo_gen2 #(
  parameter int ADDR_WIDTH = fifo_pkg::DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = fifo_pkg::DEF_DATA_WIDTH,
  parameter int AF_THRESH  = 2**ADDR_WIDTH - fifo_pkg::DEF_AF_MARGIN,
  parameter int AE_THRESH  = fifo_pkg::DEF_AE_THRESH,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Wr_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  Read_enable,
  input  logic                  clr_err,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int PW    = fifo_pkg::ptr_width(ADDR_WIDTH);
  localparam fifo_pkg::fifo_mode_e MODE = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STD;
  localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

  // Threshold sanity: an out-of-range value would pin a flag permanently.
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_af_range
    $error("fifo_gen2: AF_THRESH must lie in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_ae_range
    $error("fifo_gen2: AE_THRESH must lie in 0..DEPTH-1");
  end

  logic [ADDR_WIDTH:0]   write_ptr, read_ptr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_ok, rd_ok;

  // Full/empty come straight off the pointers; the wrap bit separates them.
  assign full  = (write_ptr[ADDR_WIDTH-1:0] == read_ptr[ADDR_WIDTH-1:0]) &&
                 (write_ptr[ADDR_WIDTH] != read_ptr[ADDR_WIDTH]);
  assign empty = (write_ptr == read_ptr);
  assign almost_full  = (count >= AF_T);
  assign almost_empty = (count <= AE_T);

  // A rejected side never disturbs state, even when the other side is accepted.
  assign wr_ok = Wr_enable && !full;
  assign rd_ok = Read_enable && !empty;

  // Gating with reset keeps a write in flight during reset out of the array.
  fifo_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) FIFO (
    .clk     (clk),
    .wr_en   (wr_ok && reset),
    .wr_addr (write_ptr[ADDR_WIDTH-1:0]),
    .wr_data (data_in),
    .rd_addr (read_ptr[ADDR_WIDTH-1:0]),
    .rd_data (rd_data)
  );

  // Pointer and occupancy update; count tracks the pointer difference.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_ptr <= '0;
      read_ptr  <= '0;
      count     <= '0;
    end else begin
      if (wr_ok) write_ptr <= write_ptr + 1'b1;
      if (rd_ok) read_ptr  <= read_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags: a new error in the clearing cycle wins over clr_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (Wr_enable && full)   || (overflow  && !clr_err);
      underflow <= (Read_enable && empty) || (underflow && !clr_err);
    end
  end

  if (MODE == fifo_pkg::FWFT) begin : g_fwft
    // Head word is always on display; it is meaningless while empty.
    assign data_out = rd_data;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    // Registered read: capture the head word on an accepted read, else hold.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)     dout_q <= '0;
      else if (rd_ok) dout_q <= rd_data;
    end
    assign data_out = dout_q;
  end

  // The counter is redundant with the pointers; they must never disagree.
  a_count_matches_ptrs: assert property (
    @(posedge clk) disable iff (!reset) count == (write_ptr - read_ptr));

endmodule

// File: tb/tb_fifo_gen2.sv
// Bench for fifo_gen2: a registered-read and an FWFT instance share one
// stimulus stream and are checked against a queue-based reference model.
module tb_fifo_gen2;

  localparam int AW = 3, DW = 32, DEPTH = 8, AF = 6, AE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, wr_en, rd_en, clr_err;
  logic [DW-1:0] data_in;

  logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [AW:0]   s_count;
  logic [DW-1:0] s_dout;
  logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [AW:0]   f_count;
  logic [DW-1:0] f_dout;

  fifo_gen2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut (
    .clk(clk), .reset(rst_n), .Wr_enable(wr_en), .data_in(data_in), .Read_enable(rd_en),
    .clr_err(clr_err), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf),
    .data_out(s_dout));

  fifo_gen2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut_f (
    .clk(clk), .reset(rst_n), .Wr_enable(wr_en), .data_in(data_in), .Read_enable(rd_en),
    .clr_err(clr_err), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf),
    .data_out(f_dout));

  // Reference model: contents as a queue, sticky flags, registered-read output.
  logic [DW-1:0] m_q[$];
  logic          m_ovf, m_unf;
  logic [DW-1:0] m_dout;

  int tests = 0;
  int fails = 0;

  task automatic model_reset();
    m_q.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_dout = '0;
  endtask

  // Drive one cycle of requests, advance the model at the edge, settle 1 time unit.
  task automatic cycle(input logic we, input logic re, input logic clr, input logic [DW-1:0] din);
    int n;
    wr_en = we; rd_en = re; clr_err = clr; data_in = din;
    @(posedge clk);
    n = m_q.size();
    m_ovf = (we && n == DEPTH) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = (re && n == 0)     ? 1'b1 : (clr ? 1'b0 : m_unf);
    if (re && n != 0)     m_dout = m_q.pop_front();
    if (we && n != DEPTH) m_q.push_back(din);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = '0;
    model_reset();
    #12;
    tests++;
    if ({s_empty, s_ae, s_full, s_af, s_ovf, s_unf} !== 6'b110000 || s_count !== 0 || s_dout !== 0) begin
      fails++;
      $display("FAIL reset_assert flags=%b count=%0d dout=%h, want flags=110000 count=0 dout=0",
               {s_empty, s_ae, s_full, s_af, s_ovf, s_unf}, s_count, s_dout);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) cycle(0, 0, 0, '0);
    tests++;
    if ({s_empty, s_ae, s_full, s_af, s_ovf, s_unf} !== 6'b110000 || s_count !== 0 || s_dout !== 0 ||
        {f_empty, f_ae, f_full, f_af, f_ovf, f_unf} !== 6'b110000 || f_count !== 0) begin
      fails++;
      $display("FAIL reset_idle std=%b/%0d/%h fwft=%b/%0d, want 110000/0/0",
               {s_empty, s_ae, s_full, s_af, s_ovf, s_unf}, s_count, s_dout,
               {f_empty, f_ae, f_full, f_af, f_ovf, f_unf}, f_count);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, 0, 0, 32'h10 + i);
      tests++;
      if (s_count !== 4'(i + 1) || s_ae !== (i + 1 <= AE) || s_af !== (i + 1 >= AF) ||
          s_full !== (i + 1 == DEPTH) || s_empty !== 1'b0) begin
        fails++;
        $display("FAIL fill_flags n=%0d count=%0d ae=%b af=%b full=%b empty=%b", i + 1,
                 s_count, s_ae, s_af, s_full, s_empty);
      end
    end
    tests++;
    if (f_dout !== 32'h10) begin
      fails++; $display("FAIL fill_fwft_head got %h want 00000010", f_dout);
    end
    cycle(1, 0, 0, 32'hDEAD);
    tests++;
    if (s_ovf !== 1'b1 || s_count !== 4'd8 || s_full !== 1'b1 || s_unf !== 1'b0) begin
      fails++;
      $display("FAIL fill_overflow ovf=%b count=%0d full=%b unf=%b, want 1/8/1/0",
               s_ovf, s_count, s_full, s_unf);
    end
  endtask

  task automatic test_drain();
    cycle(0, 0, 1, '0);
    tests++;
    if (s_ovf !== 1'b0) begin fails++; $display("FAIL drain_clr ovf=%b want 0", s_ovf); end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 1, 0, '0);
      tests++;
      if (s_dout !== 32'h10 + i || s_empty !== (i == DEPTH - 1) || s_count !== 4'(DEPTH - 1 - i)) begin
        fails++;
        $display("FAIL drain_data i=%0d dout=%h empty=%b count=%0d, want %h/%b/%0d", i,
                 s_dout, s_empty, s_count, 32'h10 + i, (i == DEPTH - 1), DEPTH - 1 - i);
      end
    end
    cycle(0, 1, 0, '0);
    tests++;
    if (s_unf !== 1'b1 || s_dout !== 32'h17 || s_count !== 0) begin
      fails++;
      $display("FAIL drain_underflow unf=%b dout=%h count=%0d, want 1/00000017/0", s_unf, s_dout, s_count);
    end
    cycle(0, 0, 1, '0);
    tests++;
    if (s_unf !== 1'b0) begin fails++; $display("FAIL drain_unf_clr unf=%b want 0", s_unf); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] nxt, rd_exp;
    nxt = 32'h100; rd_exp = 32'h100;
    for (int i = 0; i < 4; i++) begin cycle(1, 0, 0, nxt); nxt++; end
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, 0, nxt); nxt++;
      tests++;
      if (s_count !== 4'd4 || s_dout !== rd_exp || s_ovf !== 1'b0 || s_unf !== 1'b0 ||
          f_dout !== rd_exp + 1) begin
        fails++;
        $display("FAIL b2b i=%0d count=%0d dout=%h fwft=%h ovf=%b unf=%b, want 4/%h/%h/0/0",
                 i, s_count, s_dout, f_dout, s_ovf, s_unf, rd_exp, rd_exp + 1);
      end
      rd_exp++;
    end
    repeat (4) cycle(0, 1, 0, '0);
    tests++;
    if (s_empty !== 1'b1 || s_dout !== rd_exp + 3) begin
      fails++; $display("FAIL b2b_drain empty=%b dout=%h want 1/%h", s_empty, s_dout, rd_exp + 3);
    end
  endtask

  task automatic test_fwft();
    cycle(1, 0, 0, 32'hA5A5A5A5);
    tests++;
    if (f_dout !== 32'hA5A5A5A5 || f_empty !== 1'b0) begin
      fails++; $display("FAIL fwft_show dout=%h empty=%b want a5a5a5a5/0", f_dout, f_empty);
    end
    cycle(0, 1, 0, '0);
    tests++;
    if (f_empty !== 1'b1 || s_dout !== 32'hA5A5A5A5) begin
      fails++; $display("FAIL fwft_pop empty=%b std_dout=%h want 1/a5a5a5a5", f_empty, s_dout);
    end
  endtask

  task automatic test_clr_err();
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, $urandom);
    cycle(1, 0, 0, 32'h1);
    tests++;
    if (s_ovf !== 1'b1) begin fails++; $display("FAIL clr_set ovf=%b want 1", s_ovf); end
    cycle(1, 0, 1, 32'h2);
    tests++;
    if (s_ovf !== 1'b1 || f_ovf !== 1'b1) begin
      fails++; $display("FAIL clr_set_wins ovf=%b/%b want 1", s_ovf, f_ovf);
    end
    cycle(0, 0, 1, '0);
    tests++;
    if (s_ovf !== 1'b0) begin fails++; $display("FAIL clr_clean ovf=%b want 0", s_ovf); end
    repeat (3) cycle(0, 1, 0, '0);
    tests++;
    if (s_count !== 4'd5) begin fails++; $display("FAIL mid_count count=%0d want 5", s_count); end
    // Reset lands mid-cycle with a write pending; nothing of it may survive.
    wr_en = 1'b1; data_in = 32'hBAD; #2 rst_n = 1'b0; #1;
    model_reset();
    tests++;
    if ({s_empty, s_ae, s_full, s_af, s_ovf, s_unf} !== 6'b110000 || s_count !== 0 || s_dout !== 0 ||
        {f_empty, f_full, f_count} !== {2'b10, 4'd0}) begin
      fails++;
      $display("FAIL mid_reset flags=%b count=%0d dout=%h fwft_count=%0d, want 110000/0/0/0",
               {s_empty, s_ae, s_full, s_af, s_ovf, s_unf}, s_count, s_dout, f_count);
    end
    wr_en = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    cycle(0, 0, 0, '0);
    tests++;
    if (s_empty !== 1'b1 || s_count !== 0) begin
      fails++; $display("FAIL post_reset empty=%b count=%0d want 1/0", s_empty, s_count);
    end
  endtask

  task automatic test_random();
    int n, wp;
    for (int i = 0; i < 400; i++) begin
      wp = (i < 200) ? 65 : 35;
      cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < 100 - wp + 10,
            $urandom_range(0, 15) == 0, $urandom);
      n = m_q.size();
      tests++;
      if ({s_empty, s_ae, s_full, s_af, s_ovf, s_unf} !==
            {n == 0, n <= AE, n == DEPTH, n >= AF, m_ovf, m_unf} ||
          s_count !== 4'(n) || s_dout !== m_dout || f_count !== 4'(n) ||
          (n != 0 && f_dout !== m_q[0])) begin
        fails++;
        $display("FAIL random i=%0d flags=%b count=%0d dout=%h fwft=%h, want flags=%b count=%0d dout=%h",
                 i, {s_empty, s_ae, s_full, s_af, s_ovf, s_unf}, s_count, s_dout, f_dout,
                 {n == 0, n <= AE, n == DEPTH, n >= AF, m_ovf, m_unf}, n, m_dout);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_fwft();
    test_clr_err();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/fifo_gen2.md
# fifo_gen2

Parametrised synchronous FIFO, the next generation of the team's single-clock FIFO. Adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. Drop-in for existing producer/consumer paths: same write/read enable handshake, same full/empty semantics, and the same bench-facing internals (write_ptr, read_ptr, FIFO array) so the existing interface and TB keep hooking them hierarchically.

## Interface
- ADDR_WIDTH, 3: depth is DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32: word width.
- AF_THRESH, DEPTH-2: almost_full asserted when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2: almost_empty asserted when count <= AE_THRESH; legal range 0..DEPTH-1.
- FWFT, 0: 0 = registered read (standard); 1 = first-word-fall-through.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Wr_enable  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- Read_enable  in  1  read request.
- clr_err  in  1  synchronous clear of overflow/underflow.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- data_out  out  DATA_WIDTH  read data.

## Operation
- Pointers write_ptr/read_ptr are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits index the FIFO array, and the MSB is the wrap bit. full = (addr equal, wrap bits differ); empty = pointers equal. Pointers wrap naturally modulo 2*DEPTH.
- Write accepted iff Wr_enable && !full: FIFO[write_ptr] <= data_in, write_ptr++.
- Read accepted iff Read_enable && !empty: read_ptr++.
- Write when full is rejected, even with a simultaneous accepted read. The array, pointers and count are untouched, and overflow sets.
- Read when empty is rejected, even with a simultaneous write. read_ptr holds, data_out holds, and underflow sets.
- Simultaneous accepted read and write: both pointers advance and count is unchanged.
- count is a registered counter with +1, -1 or 0 per cycle. It must always equal write_ptr - read_ptr; this is an assertion.
- overflow/underflow: set-priority SR flops. clr_err clears them the next edge unless a new error occurs in the same cycle, in which case set wins.
- FWFT=0: on an accepted read, data_out <= FIFO[read_ptr[ADDR_WIDTH-1:0]]; otherwise it holds.
- FWFT=1: data_out = FIFO[read_ptr] combinationally. It is valid whenever !empty and don't-care when empty. An accepted read pops the displayed word.
- Reset (async assert, any time including mid-burst): pointers = 0, count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = underflow = 0, and data_out = 0 in FWFT=0. Array contents are not reset. Any operation in flight during assertion is lost.

## Timing
- All flags and count are decoded from registered state and change only on the rising edge that commits an operation. There are no combinational input-to-flag paths.
- Write latency: a word written at edge N makes empty deassert after edge N.
  - FWFT=1: the word appears on data_out after edge N.
  - FWFT=0: the earliest read request is in cycle N+1, and data appears after edge N+1 (one-cycle read latency).
- full asserts after the edge committing the DEPTH-th outstanding write, and deasserts after the edge committing the next read.
- Error flags assert the edge after the offending request, and stay asserted until clr_err or reset.
- Reset deassertion is synchronised externally. The block assumes recovery/removal is met.

## Structure
- Package fifo_pkg: the fifo_mode_e enum (STD, FWFT), the function for ptr_width(ADDR_WIDTH), and the default threshold constants.
- Sub-module fifo_mem: a DEPTH x DATA_WIDTH register array with one write port and one asynchronous read port, instance-named so that dut.FIFO and the pointer names stay visible to the interface.
- Top-level: pointer/count/flag logic and the FWFT output mux.
- Elaboration-time assertions check the legal threshold ranges.

## Test plan
Configuration for all scenarios: ADDR_WIDTH=3, DATA_WIDTH=32, AF_THRESH=6, AE_THRESH=2.
- Reset, then idle 3 cycles -> empty=1, almost_empty=1, full=0, count=0, data_out=0, overflow=underflow=0.
- Write 0x10..0x17 (8 words) -> almost_empty drops when count reaches 3, almost_full rises when count reaches 6, full=1 at count=8. A 9th write of 0xDEAD gives overflow=1 with count still 8.
- Read 8 words (FWFT=0) -> data_out is 0x10..0x17 in order, each one cycle after its read. empty=1 after the 8th read. A 9th read gives underflow=1 and data_out holds 0x17.
- Fill to 4 words, then 20 cycles of simultaneous read+write of incrementing data -> count stays 4, in-order data crosses the pointer wrap, and no error flags are raised.
- FWFT=1: write 0xA5A5A5A5 -> data_out=0xA5A5A5A5 the cycle after the write with no read; after a read, empty=1.
- Set overflow, pulse clr_err together with another write-when-full -> overflow stays 1; a clean clr_err next cycle -> 0. Assert reset mid-burst at count=5 -> all outputs return to reset values immediately.
